// File: rtl/sw_led_pkg.sv
// Shared types for the switch-to-LED controller: mode encoding and mode step.
package sw_led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS  = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  // Button-driven mode rotation, wrapping OFF back to PASS.
  function automatic mode_e mode_next(input mode_e m);
    mode_e r;
    r = MODE_PASS;
    case (m)
      MODE_PASS:  r = MODE_BLINK;
      MODE_BLINK: r = MODE_CHASE;
      MODE_CHASE: r = MODE_OFF;
      MODE_OFF:   r = MODE_PASS;
      default:    r = MODE_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sw_led_debounce.sv
// One-bit debouncer: 2-flop synchroniser followed by a stability counter.
// The stable value only follows the input after DEBOUNCE_CYCLES consecutive
// differing samples; any return to the stable value restarts the count.
module sw_led_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic stable_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing samples; commit the new value on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// Debounced, mode-driven LED sequencer (PASS / BLINK / CHASE / OFF).
// Optional build macro SW_LED_PWM_EN adds a fixed-duty PWM dimming gate
// inside the output register.
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int unsigned N_LED           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned PWM_PERIOD      = 16,
  parameter int unsigned PWM_DUTY        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LED-1:0]  sw,
  input  logic              btn_mode,
  output logic [N_LED-1:0]  led,
  output logic [MODE_W-1:0] mode
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned PW = $clog2(N_LED);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N_LED - 1);

  if (PWM_DUTY > PWM_PERIOD) begin : g_bad_pwm_cfg
    $error("PWM_DUTY must not exceed PWM_PERIOD");
  end

  logic [N_LED-1:0] sw_db;
  logic             btn_db;

  genvar i;
  for (i = 0; i < N_LED; i++) begin : g_sw_db
    sw_led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_i    (sw[i]),
      .stable_o (sw_db[i])
    );
  end

  sw_led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_i    (btn_mode),
    .stable_o (btn_db)
  );

  logic             btn_prev_q;
  mode_e            mode_q, mode_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             phase_q, phase_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [N_LED-1:0] led_q, led_d, led_raw;
  logic [N_LED-1:0] chase_mask;
  logic             mode_adv, run, tick;

  assign mode_adv   = btn_db & ~btn_prev_q;
  assign run        = (mode_q == MODE_BLINK) || (mode_q == MODE_CHASE);
  assign tick       = run && (tick_cnt_q == TICK_LAST);
  assign chase_mask = {{(N_LED-1){1'b0}}, 1'b1} << pos_q;

  // Mode rotation and tick-driven sequencer; a mode change overrides a same-cycle tick.
  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    if (mode_adv) begin
      mode_d     = mode_next(mode_q);
      tick_cnt_d = '0;
      phase_d    = 1'b0;
      pos_d      = '0;
    end else if (!run) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
      phase_d    = ~phase_q;
      pos_d      = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // LED pattern for the current mode, before any dimming gate.
  always_comb begin
    led_raw = '0;
    case (mode_q)
      MODE_PASS:  led_raw = sw_db;
      MODE_BLINK: led_raw = phase_q ? sw_db : '0;
      MODE_CHASE: led_raw = sw_db & chase_mask;
      MODE_OFF:   led_raw = '0;
      default:    led_raw = '0;
    endcase
  end

`ifdef SW_LED_PWM_EN
  localparam int unsigned PWMW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [PWMW-1:0] PWM_LAST = PWMW'(PWM_PERIOD - 1);

  logic [PWMW-1:0] pwm_cnt_q;
  logic            pwm_on;

  // Free-running PWM counter, independent of mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    end
  end

  assign pwm_on = 32'(pwm_cnt_q) < PWM_DUTY;
  assign led_d  = led_raw & {N_LED{pwm_on}};
`else
  assign led_d  = led_raw;
`endif

  // Controller state and registered LED output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      mode_q     <= MODE_PASS;
      tick_cnt_q <= '0;
      phase_q    <= 1'b0;
      pos_q      <= '0;
      led_q      <= '0;
    end else begin
      btn_prev_q <= btn_db;
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      led_q      <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed self-checking bench for sw_led_ctrl with small timing parameters.
module tb_sw_led_ctrl;

  localparam int unsigned N_LED           = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned TICK_DIV        = 8;
  localparam int unsigned PWM_PERIOD      = 4;
  localparam int unsigned PWM_DUTY        = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_LED-1:0] sw;
  logic             btn_mode;
  logic [N_LED-1:0] led;
  logic [1:0]       mode;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sw_led_ctrl #(
    .N_LED           (N_LED),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .TICK_DIV        (TICK_DIV),
    .PWM_PERIOD      (PWM_PERIOD),
    .PWM_DUTY        (PWM_DUTY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_mode (btn_mode),
    .led      (led),
    .mode     (mode)
  );

`ifdef SW_LED_PWM_EN
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_mode = 1'b1;
    step(8);
    btn_mode = 1'b0;
    step(8);
  endtask

  logic [N_LED-1:0] exp_led;
  logic [N_LED-1:0] sw_eff;

  initial begin
    rst_n    = 1'b0;
    sw       = '0;
    btn_mode = 1'b0;
    step(3);
    check_eq("rst_led", 32'(led), 32'h0);
    check_eq("rst_mode", 32'(mode), 32'd0);
    rst_n = 1'b1;
    step(2);

`ifdef SW_LED_PWM_EN
    sw = 4'b1111;
    step(12);
    for (int k = 0; k < 8; k++) begin
      step(1);
      exp_led = (((cyc - 1) % PWM_PERIOD) < PWM_DUTY) ? 4'b1111 : 4'b0000;
      check_eq($sformatf("pwm_%0d", k), 32'(led), 32'(exp_led));
    end
`else
    // Input-to-LED latency: 2 sync + 4 debounce + 1 output register.
    sw = 4'b1010;
    step(6);
    check_eq("lat_early", 32'(led), 32'h0);
    step(1);
    check_eq("lat_exact", 32'(led), 32'ha);

    // Short glitch is rejected, long pulse passes.
    sw = 4'b1011;
    step(3);
    sw = 4'b1010;
    step(12);
    check_eq("glitch3", 32'(led), 32'ha);
    sw = 4'b1011;
    step(6);
    check_eq("pulse6_pre", 32'(led), 32'ha);
    sw = 4'b1010;
    step(1);
    check_eq("pulse6_hi", 32'(led), 32'hb);
    step(12);
    check_eq("pulse6_lo", 32'(led), 32'ha);

    // Mode rotation and hold without repeat.
    press(); check_eq("mode_p1", 32'(mode), 32'd1);
    press(); check_eq("mode_p2", 32'(mode), 32'd2);
    press(); check_eq("mode_p3", 32'(mode), 32'd3);
    press(); check_eq("mode_p4", 32'(mode), 32'd0);
    btn_mode = 1'b1;
    step(50);
    check_eq("hold_on", 32'(mode), 32'd1);
    btn_mode = 1'b0;
    step(10);
    check_eq("hold_off", 32'(mode), 32'd1);
    press(); press(); press();
    check_eq("mode_back0", 32'(mode), 32'd0);
    sw = 4'b1111;
    step(10);
    check_eq("pass_1111", 32'(led), 32'hf);

    // Enter BLINK with exact timing: mode updates 7 edges after the press.
    btn_mode = 1'b1;
    step(6);
    check_eq("adv_early", 32'(mode), 32'd0);
    step(1);
    check_eq("adv_blink", 32'(mode), 32'd1);
    btn_mode = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      exp_led = (((k - 1) / 8) % 2 == 1) ? 4'b1111 : 4'b0000;
      check_eq($sformatf("blink_%0d", k), 32'(led), 32'(exp_led));
    end

    // Enter CHASE; change switches mid-sequence.
    btn_mode = 1'b1;
    step(7);
    btn_mode = 1'b0;
    check_eq("adv_chase", 32'(mode), 32'd2);
    for (int k = 1; k <= 82; k++) begin
      step(1);
      sw_eff  = (k >= 47) ? 4'b0101 : 4'b1111;
      exp_led = sw_eff & (4'b0001 << (((k - 1) / 8) % 4));
      check_eq($sformatf("chase_%0d", k), 32'(led), 32'(exp_led));
      if (k == 40) sw = 4'b0101;
    end

    // Asynchronous reset mid-chase clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_led", 32'(led), 32'h0);
    check_eq("async_rst_mode", 32'(mode), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
